// File: rtl/keypoint_reader.sv
// Reads keypoint coordinates from two layer SRAMs (layer 0 first, then layer 1)
// and streams them through a 2-entry FIFO with valid/ready handshake.
module keypoint_reader #(
    parameter int ADDR_W = 11,
    parameter int ROW_W  = 9,
    parameter int COL_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        kp_1_count,
    input  logic [ADDR_W-1:0]        kp_2_count,
    output logic [ADDR_W-1:0]        kp_1_addr,
    input  logic [ROW_W+COL_W-1:0]   kp_1_dout,
    output logic [ADDR_W-1:0]        kp_2_addr,
    input  logic [ROW_W+COL_W-1:0]   kp_2_dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROW_W-1:0]         out_row,
    output logic [COL_W-1:0]         out_col,
    output logic                     out_layer,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W:0]          kp_total
);

    // state | meaning
    // IDLE  | waiting for start
    // RD_1  | issuing reads to layer-0 SRAM
    // RD_2  | issuing reads to layer-1 SRAM
    // DRAIN | all reads issued, waiting for FIFO and in-flight read to empty

    localparam int DW = ROW_W + COL_W;
    localparam int EW = DW + 1;

    typedef enum logic [1:0] {IDLE, RD_1, RD_2, DRAIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt_1;
    logic [ADDR_W-1:0]   cnt_2;
    logic                in_flight;
    logic                flight_layer;
    logic [EW-1:0]       fifo_mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          occ;

    logic                pop;
    logic                issue;
    logic [2:0]          load;
    logic [EW-1:0]       head;
    logic [EW-1:0]       wdata;

    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign head      = fifo_mem[rd_ptr];
    assign out_layer = head[DW];
    assign out_row   = head[DW-1:COL_W];
    assign out_col   = head[COL_W-1:0];
    assign wdata     = flight_layer ? {1'b1, kp_2_dout} : {1'b0, kp_1_dout};

    // Occupancy as it will stand after this edge; counting the pop keeps
    // one-per-cycle throughput while still bounding the FIFO at 2 entries.
    assign load  = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
    assign issue = ((state == RD_1) || (state == RD_2)) && (load < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt_1        <= '0;
            cnt_2        <= '0;
            kp_1_addr    <= '0;
            kp_2_addr    <= '0;
            in_flight    <= 1'b0;
            flight_layer <= 1'b0;
            fifo_mem[0]  <= '0;
            fifo_mem[1]  <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            occ          <= 2'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            kp_total     <= '0;
        end else begin
            done <= 1'b0;

            if (in_flight) begin
                fifo_mem[wr_ptr] <= wdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                kp_total <= kp_total + 1'b1;
            end
            if (in_flight && !pop)
                occ <= occ + 2'd1;
            else if (!in_flight && pop)
                occ <= occ - 2'd1;

            in_flight <= issue;
            if (issue)
                flight_layer <= (state == RD_2);

            case (state)
                IDLE: begin
                    if (start) begin
                        cnt_1     <= kp_1_count;
                        cnt_2     <= kp_2_count;
                        kp_total  <= '0;
                        kp_1_addr <= '0;
                        kp_2_addr <= '0;
                        busy      <= 1'b1;
                        if (kp_1_count != '0)
                            state <= RD_1;
                        else if (kp_2_count != '0)
                            state <= RD_2;
                        else
                            state <= DRAIN;
                    end
                end
                RD_1: begin
                    if (issue) begin
                        kp_1_addr <= kp_1_addr + 1'b1;
                        if (kp_1_addr == cnt_1 - 1'b1)
                            state <= (cnt_2 == '0) ? DRAIN : RD_2;
                    end
                end
                RD_2: begin
                    if (issue) begin
                        kp_2_addr <= kp_2_addr + 1'b1;
                        if (kp_2_addr == cnt_2 - 1'b1)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((occ == 2'd0) && !in_flight) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypoint_reader.sv
// Scoreboard bench for keypoint_reader: stimulus pushes expected keypoints,
// a negedge monitor pops and compares on every transfer.
module tb_keypoint_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] kp_1_count = '0;
    logic [10:0] kp_2_count = '0;
    logic [10:0] kp_1_addr;
    logic [18:0] kp_1_dout = '0;
    logic [10:0] kp_2_addr;
    logic [18:0] kp_2_dout = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  out_row;
    logic [9:0]  out_col;
    logic        out_layer;
    logic        busy;
    logic        done;
    logic [11:0] kp_total;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;   // 0: ready high, 1: ready toggles, 2: ready low

    logic [19:0] expq[$];
    logic        held_v = 1'b0;
    logic [19:0] held   = '0;

    keypoint_reader dut (
        .clk(clk), .rst(rst), .start(start),
        .kp_1_count(kp_1_count), .kp_2_count(kp_2_count),
        .kp_1_addr(kp_1_addr), .kp_1_dout(kp_1_dout),
        .kp_2_addr(kp_2_addr), .kp_2_dout(kp_2_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_layer(out_layer),
        .busy(busy), .done(done), .kp_total(kp_total)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] mem1(input int a);
        logic [8:0] r;
        logic [9:0] c;
        r = 9'((a * 7 + 3) % 512);
        c = 10'((a * 13 + 5) % 1024);
        return {r, c};
    endfunction

    function automatic logic [18:0] mem2(input int a);
        logic [8:0] r;
        logic [9:0] c;
        r = 9'((a * 5 + 100) % 512);
        c = 10'((a * 11 + 700) % 1024);
        return {r, c};
    endfunction

    // Synchronous-read SRAM models
    always @(posedge clk) begin
        kp_1_dout <= mem1(int'(kp_1_addr));
        kp_2_dout <= mem2(int'(kp_2_addr));
    end

    always @(posedge clk) begin
        #2;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [19:0] cur;
        logic [19:0] e;
        cur = {out_layer, out_row, out_col};
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v)
                check("stall_hold", {11'd0, out_valid, cur}, {11'd0, 1'b1, held});
            if (out_valid) begin
                if (out_ready) begin
                    check("expected_available", 32'(expq.size() != 0), 32'd1);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        check("out_data", {12'd0, cur}, {12'd0, e});
                    end
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held   = cur;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // Returns at the negedge of cycle N+1 (start accepted at edge N).
    task automatic start_pass(input int c1, input int c2);
        @(negedge clk);
        for (int i = 0; i < c1; i++) expq.push_back({1'b0, mem1(i)});
        for (int i = 0; i < c2; i++) expq.push_back({1'b1, mem2(i)});
        kp_1_count = 11'(c1);
        kp_2_count = 11'(c2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {kp_1_addr, kp_2_addr, out_valid, busy, done},
              {11'd0, 11'd0, 3'b000});
        check("reset_total", {20'd0, kp_total}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic pass, latency and back-to-back throughput
        mode = 0;
        start_pass(3, 2);
        check("lat_addr_n1", {21'd0, kp_1_addr}, 32'd0);
        check("lat_busy_n1", {31'd0, busy}, 32'd1);
        check("lat_valid_n1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_valid_n2", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        wait_done(50);
        check("total_basic", {20'd0, kp_total}, 32'd5);
        check("queue_empty_basic", 32'(expq.size()), 32'd0);

        // Toggling ready
        mode = 1;
        start_pass(3, 2);
        wait_done(100);
        check("total_toggle", {20'd0, kp_total}, 32'd5);
        check("queue_empty_toggle", 32'(expq.size()), 32'd0);
        mode = 0;

        // Layer 0 empty
        start_pass(0, 4);
        wait_done(50);
        check("l1_addr_idle", {21'd0, kp_1_addr}, 32'd0);
        check("total_l1_only", {20'd0, kp_total}, 32'd4);

        // Both empty: done at N+2
        start_pass(0, 0);
        check("zero_done_n1", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("zero_done_n2", {31'd0, done}, 32'd1);
        check("zero_valid", {31'd0, out_valid}, 32'd0);
        check("zero_total", {20'd0, kp_total}, 32'd0);

        // Consumer stalled for 10 cycles
        mode = 2;
        start_pass(3, 2);
        repeat (9) @(negedge clk);
        check("stall_reads", {21'd0, kp_1_addr}, 32'd2);
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_total", {20'd0, kp_total}, 32'd0);
        mode = 0;
        wait_done(50);
        check("total_stall", {20'd0, kp_total}, 32'd5);

        // Reset mid-pass
        start_pass(3, 2);
        for (int i = 0; i < 20; i++) begin
            if (kp_total == 12'd2) break;
            @(negedge clk);
        end
        check("mid_total", {20'd0, kp_total}, 32'd2);
        #1 rst = 1'b1;
        #1;
        check("arst_ctrl", {kp_1_addr, kp_2_addr, out_valid, busy, done},
              {11'd0, 11'd0, 3'b000});
        check("arst_total", {20'd0, kp_total}, 32'd0);
        check("arst_data", {12'd0, out_layer, out_row, out_col}, 32'd0);
        expq.delete();
        @(negedge clk);
        rst = 1'b0;
        start_pass(3, 2);
        check("replay_addr", {21'd0, kp_1_addr}, 32'd0);
        wait_done(50);
        check("total_replay", {20'd0, kp_total}, 32'd5);

        // Maximum count, no address wrap
        start_pass(2047, 1);
        wait_done(2200);
        check("max_total", {20'd0, kp_total}, 32'd2048);
        check("max_addr_end", {21'd0, kp_1_addr}, 32'd2047);
        check("queue_empty_max", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypoint_reader.md
KEYPOINT_READER -- requirements
Module: keypoint_reader

Interface
REQ-001 Parameter ADDR_W, default 11, keypoint SRAM address width (2K entries per layer).
REQ-002 Parameter ROW_W, default 9, row field width; COL_W, default 10, column field width; entry word = {row, col}, 19 bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle pulse; begins a readout pass.
REQ-006 kp_1_count  input  ADDR_W  number of valid entries in keypoint SRAM 1 (layer 0), sampled at start.
REQ-007 kp_2_count  input  ADDR_W  number of valid entries in keypoint SRAM 2 (layer 1), sampled at start.
REQ-008 kp_1_addr  output  ADDR_W  registered read address to keypoint SRAM 1.
REQ-009 kp_1_dout  input  ROW_W+COL_W  SRAM 1 read data, valid one cycle after the address is presented.
REQ-010 kp_2_addr / kp_2_dout  output ADDR_W / input ROW_W+COL_W  same as REQ-008/009 for SRAM 2.
REQ-011 out_valid  output  1  output keypoint available.
REQ-012 out_ready  input  1  consumer accepts; transfer occurs when out_valid and out_ready are both high.
REQ-013 out_row / out_col / out_layer  output  ROW_W / COL_W / 1  keypoint coordinates; layer 0 = SRAM 1, layer 1 = SRAM 2.
REQ-014 busy  output  1  high from the cycle after start is accepted until done.
REQ-015 done  output  1  one-cycle pulse at the end of a pass.
REQ-016 kp_total  output  ADDR_W+1  number of keypoints transferred in the current or last pass.

Function
REQ-017 The FSM shall have states IDLE, RD_1, RD_2, DRAIN.
REQ-018 In IDLE, start shall latch both counts, clear kp_total, zero both addresses, and move to RD_1; if kp_1_count is 0, it shall move to RD_2 instead; if both counts are 0, it shall move to DRAIN.
REQ-019 Start while busy shall be ignored.
REQ-020 A read shall be issued in a cycle only if FIFO occupancy plus reads in flight is below 2; at most one read is in flight.
REQ-021 Each issued read shall increment the active layer address at the following edge.
REQ-022 RD_1 shall move to RD_2 (or DRAIN if kp_2_count is 0) once address kp_1_count-1 has been issued.
REQ-023 RD_2 shall move to DRAIN once address kp_2_count-1 has been issued.
REQ-024 Returned data shall be written, with its layer tag, into a 2-entry output FIFO one cycle after issue; the FIFO shall never overflow.
REQ-025 out_valid shall equal FIFO not-empty; the out_* fields shall be taken from the FIFO head.
REQ-026 Once out_valid is asserted, out_* shall hold stable until the transfer occurs.
REQ-027 A FIFO write and read in the same cycle shall leave occupancy unchanged.
REQ-028 kp_total shall increment on each transfer.
REQ-029 With out_ready held high, throughput shall be one keypoint per cycle after the pipeline fills.
REQ-030 Latency: with start accepted at edge N and kp_1_count nonzero, kp_1_addr shall be 0 in cycle N+1 and out_valid shall first be high in cycle N+3.
REQ-031 Order shall be all layer-0 entries in ascending address order, then all layer-1 entries.
REQ-032 DRAIN shall wait until the FIFO is empty and no read is in flight, then pulse done for one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-033 With both counts 0, done shall pulse in cycle N+2 and out_valid shall never rise.
REQ-034 A count of 2047 shall read addresses 0..2046 with no address wrap.

Reset
REQ-035 Asserting rst at any time, including mid-pass, shall immediately force IDLE, clear the FIFO and in-flight flag, and drive out_valid=0, busy=0, done=0, kp_1_addr=0, kp_2_addr=0, kp_total=0, out_row=0, out_col=0, out_layer=0.
REQ-036 After rst deasserts, the block shall accept start on the next rising edge.

Verification
REQ-037 kp_1_count=3, kp_2_count=2, out_ready=1 -> five transfers in consecutive cycles starting N+3, layers 0,0,0,1,1, data matching SRAM contents, done pulse, kp_total=5.
REQ-038 Same counts, out_ready toggling 1/0 each cycle -> identical transfer sequence, out_* stable while stalled, no loss or duplication.
REQ-039 kp_1_count=0, kp_2_count=4 -> only layer-1 transfers, kp_1_addr stays 0.
REQ-040 Both counts 0 -> done in cycle N+2, out_valid never high, kp_total=0.
REQ-041 out_ready=0 for 10 cycles after start -> at most 2 reads issued, FIFO full, then drains correctly once ready rises.
REQ-042 rst asserted after 2 of 5 transfers -> all outputs reach reset values asynchronously; a new start then replays from address 0.
